mips_lsu: RTL and testbench
===========================

MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, width of pipeline and RAM addresses.
REQ-002 Parameter CNT_W, default 16, width of the access statistics counters.
REQ-003 clk  input  1  single clock; RAM writes and all LSU state update on rising edge.
REQ-004 CLR_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid / req_ready  input / output  1 / 1  MEM-stage request handshake; transfer when both high at a rising edge.
REQ-006 req_we, req_size[1:0], req_unsigned  input  1/2/1  store flag; size 00 byte, 01 half, 10 word, 11 illegal; zero-extend load.
REQ-007 req_addr[ADDR_W-1:0], req_wdata[31:0]  input  byte address; store data, right-aligned.
REQ-008 resp_valid / resp_ready  output / input  1 / 1  response handshake to writeback.
REQ-009 resp_rdata[31:0], resp_err  output  32/1  load result; misaligned or illegal-size flag.
REQ-010 ram_addr[31:0], ram_data_in[31:0], ram_MemWrite, ram_Byte, ram_Half, ram_UnsignedExt_Mem  output  RAM request side.
REQ-011 ram_data_out[31:0]  input  RAM combinational read data, already extended.
REQ-012 ld_cnt, st_cnt, err_cnt[CNT_W-1:0]  output  saturating statistics counters.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, RESP; req_ready SHALL be high only in IDLE.
REQ-014 On acceptance, the LSU SHALL latch we, size, unsigned, addr, wdata into request registers.
REQ-015 Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size 11; IDLE->RESP directly, resp_err=1, resp_rdata=0, RAM untouched.
REQ-016 Aligned: IDLE->ISSUE->RESP; resp_valid first high 2 cycles after acceptance (misaligned: 1 cycle).
REQ-017 RAM outputs SHALL be driven only from the request registers; ram_Byte=(size==00), ram_Half=(size==01), ram_UnsignedExt_Mem=unsigned, ram_data_in=wdata.
REQ-018 ram_MemWrite SHALL be high only in ISSUE and only when we=1, for exactly one cycle per store.
REQ-019 On the ISSUE->RESP edge, a load SHALL capture ram_data_out into resp_rdata; a store SHALL set resp_rdata=0.
REQ-020 In RESP, resp_valid SHALL stay high with stable rdata/err until resp_ready; then RESP->IDLE.
REQ-021 No new request SHALL be accepted in the cycle resp handshake completes (one idle-ready bubble).
REQ-022 ld_cnt/st_cnt SHALL increment on each aligned load/store leaving ISSUE; err_cnt on each misaligned acceptance; all saturate at all-ones.
REQ-023 Outside ISSUE, ram_MemWrite SHALL be 0 regardless of request register contents.

Reset
REQ-024 CLR_n low SHALL immediately force IDLE, resp_valid=0, resp_err=0, resp_rdata=0, ram_MemWrite=0, request registers and counters 0.
REQ-025 Reset asserted during ISSUE SHALL suppress the pending store (MemWrite deasserted asynchronously, no RAM write).
REQ-026 After CLR_n release, req_ready SHALL be high from the first clock edge.

Structure
REQ-027 Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and state encodings SHALL live in shared package mips_mem_pkg.
REQ-028 Misalignment detection SHALL be a combinational sub-module mips_align_chk (addr[1:0], size -> err).
REQ-029 No memory array SHALL be inside mips_lsu; the RAM is instantiated alongside it.

Verification
REQ-030 Store word 0xDEADBEEF at 0x10, then load word 0x10 -> ram_MemWrite one cycle, resp_rdata=0xDEADBEEF, st_cnt=1, ld_cnt=1.
REQ-031 Store byte 0x80 at 0x21, load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
REQ-032 Load half at 0x23 -> resp_err=1 one cycle after acceptance, no RAM write, err_cnt=1; size 11 at 0x20 likewise.
REQ-033 Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-034 Assert CLR_n low mid-ISSUE of a store to 0x30 -> subsequent load of 0x30 returns prior value, counters 0.
REQ-035 Force 2^CNT_W+2 loads (CNT_W=4 override) -> ld_cnt saturates at 0xF.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS load/store path.
//   SZ_*        : access size encoding carried on req_size
//   lsu_state_e : LSU request FSM states
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StResp  = 2'b10
  } lsu_state_e;

endpackage

// File: rtl/mips_align_chk.sv
// Combinational alignment checker for a single memory access.
//   addr_lo : low two bits of the byte address
//   size    : access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL)
//   err     : high for a misaligned access or an illegal size
module mips_align_chk
  import mips_mem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] size,
  output logic       err
);

  always_comb begin
    err = 1'b1;
    unique case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = |addr_lo;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MEM-stage load/store unit. Accepts one request at a time, issues it to an
// external combinational-read RAM for one cycle, and holds the response until
// writeback takes it. Misaligned / illegal-size requests skip the RAM entirely.
//   clk, CLR_n            : clock, asynchronous active-low reset
//   req_*                 : request handshake and fields from the pipeline
//   resp_*                : response handshake, load data and error flag
//   ram_*                 : RAM request side (driven from latched request only)
//   ram_data_out          : RAM read data, already size-extended by the RAM
//   ld_cnt/st_cnt/err_cnt : saturating access statistics
module mips_lsu
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              CLR_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_data_in,
  output logic              ram_MemWrite,
  output logic              ram_Byte,
  output logic              ram_Half,
  output logic              ram_UnsignedExt_Mem,
  input  logic [31:0]       ram_data_out,
  output logic [CNT_W-1:0]  ld_cnt,
  output logic [CNT_W-1:0]  st_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  lsu_state_e state_q, state_d;

  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  ld_q, st_q, errc_q;

  logic align_err;
  logic accept;

  mips_align_chk u_align_chk (
    .addr_lo (req_addr[1:0]),
    .size    (req_size),
    .err     (align_err)
  );

  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_valid) state_d = align_err ? StResp : StIssue;
      StIssue: state_d = StResp;
      StResp:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready           = (state_q == StIdle);
    resp_valid          = (state_q == StResp);
    resp_rdata          = rdata_q;
    resp_err            = err_q;
    // Gated by state so a reset during ISSUE drops the write asynchronously.
    ram_MemWrite        = (state_q == StIssue) && we_q;
    ram_addr            = 32'(addr_q);
    ram_data_in         = wdata_q;
    ram_Byte            = (size_q == SZ_BYTE);
    ram_Half            = (size_q == SZ_HALF);
    ram_UnsignedExt_Mem = uns_q;
    ld_cnt              = ld_q;
    st_cnt              = st_q;
    err_cnt             = errc_q;
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept && align_err) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if (state_q == StIssue) begin
      rdata_q <= we_q ? 32'h0 : ram_data_out;
      err_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      ld_q   <= '0;
      st_q   <= '0;
      errc_q <= '0;
    end else begin
      if (state_q == StIssue) begin
        if (we_q && (st_q != CntMax)) st_q <= st_q + CNT_W'(1);
        if (!we_q && (ld_q != CntMax)) ld_q <= ld_q + CNT_W'(1);
      end
      if (accept && align_err && (errc_q != CntMax)) errc_q <= errc_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: a byte-array RAM sits beside the DUT, and a
// transaction-level reference (separate byte array + saturating counts) predicts
// every response, latency, write count and statistic.
module tb_mips_lsu;
  import mips_mem_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              CLR_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [31:0]       ram_addr;
  logic [31:0]       ram_data_in;
  logic              ram_MemWrite;
  logic              ram_Byte;
  logic              ram_Half;
  logic              ram_UnsignedExt_Mem;
  logic [31:0]       ram_data_out;
  logic [CNT_W-1:0]  ld_cnt, st_cnt, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_lsu #(.ADDR_W(32), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .CLR_n               (CLR_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_we              (req_we),
    .req_size            (req_size),
    .req_unsigned        (req_unsigned),
    .req_addr            (req_addr),
    .req_wdata           (req_wdata),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_rdata          (resp_rdata),
    .resp_err            (resp_err),
    .ram_addr            (ram_addr),
    .ram_data_in         (ram_data_in),
    .ram_MemWrite        (ram_MemWrite),
    .ram_Byte            (ram_Byte),
    .ram_Half            (ram_Half),
    .ram_UnsignedExt_Mem (ram_UnsignedExt_Mem),
    .ram_data_out        (ram_data_out),
    .ld_cnt              (ld_cnt),
    .st_cnt              (st_cnt),
    .err_cnt             (err_cnt)
  );

  // Environment RAM: 256 bytes, little-endian, combinational extended read.
  logic [7:0] mem [256];
  logic       fill = 1'b0;
  logic [7:0] ra;
  assign ra = ram_addr[7:0];

  always_comb begin
    ram_data_out = 32'h0;
    if (ram_Byte) begin
      ram_data_out = ram_UnsignedExt_Mem ? {24'h0, mem[ra]} : {{24{mem[ra][7]}}, mem[ra]};
    end else if (ram_Half) begin
      ram_data_out = ram_UnsignedExt_Mem ? {16'h0, mem[ra+8'd1], mem[ra]}
                                         : {{16{mem[ra+8'd1][7]}}, mem[ra+8'd1], mem[ra]};
    end else begin
      ram_data_out = {mem[ra+8'd3], mem[ra+8'd2], mem[ra+8'd1], mem[ra]};
    end
  end

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (ram_MemWrite) begin
      mem[ra] <= ram_data_in[7:0];
      if (!ram_Byte) mem[ra+8'd1] <= ram_data_in[15:8];
      if (!ram_Byte && !ram_Half) begin
        mem[ra+8'd2] <= ram_data_in[23:16];
        mem[ra+8'd3] <= ram_data_in[31:24];
      end
    end
  end

  // Reference model state.
  byte unsigned ref_mem [256];
  int m_ld = 0, m_st = 0, m_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_misaligned(input logic [1:0] sz, input int a);
    if (sz == 2'd3) return 1'b1;
    if (sz == 2'd1) return (a % 2) != 0;
    if (sz == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input int a);
    int v;
    if (sz == 2'd0) begin
      v = ref_mem[a];
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = ref_mem[a] + 256 * ref_mem[a+1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = ref_mem[a] + (ref_mem[a+1] << 8) + (ref_mem[a+2] << 16) + (ref_mem[a+3] << 24);
    end
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] d);
    int nbytes;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int i = 0; i < nbytes; i++) ref_mem[a+i] = 8'((d >> (8 * i)) & 32'hFF);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wd, input int hold);
    logic        exp_err;
    logic [31:0] exp_rd;
    int          lat, wr_cnt, guard;
    exp_err = ref_misaligned(sz, int'(addr));
    exp_rd  = (exp_err || we) ? 32'h0 : ref_load(sz, uns, int'(addr));

    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = {24'h0, addr}; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = 0; wr_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ram_MemWrite) wr_cnt++;
      if (!resp_valid && lat == 1) begin
        check("issue_addr", ram_addr, {24'h0, addr});
        check("issue_rdy", {31'h0, req_ready}, 32'h0);
      end
    end while (!resp_valid && lat < 8);
    check("latency", 32'(lat), exp_err ? 32'd1 : 32'd2);
    check("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_rdy", {31'h0, req_ready}, 32'h0);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ram_MemWrite) wr_cnt++;
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_rdata", resp_rdata, exp_rd);
      check("hold_err", {31'h0, resp_err}, {31'h0, exp_err});
      check("hold_rdy", {31'h0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("post_valid", {31'h0, resp_valid}, 32'h0);
    check("post_rdy", {31'h0, req_ready}, 32'h1);
    check("wr_count", 32'(wr_cnt), (we && !exp_err) ? 32'd1 : 32'd0);

    if (exp_err) begin
      if (m_err < CMAX) m_err++;
    end else if (we) begin
      ref_store(sz, int'(addr), wd);
      if (m_st < CMAX) m_st++;
    end else begin
      if (m_ld < CMAX) m_ld++;
    end
    check("ld_cnt", 32'(ld_cnt), 32'(m_ld));
    check("st_cnt", 32'(st_cnt), 32'(m_st));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz;
    logic [7:0]  a;
    logic [31:0] saved;

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

    // Reset state, with RAM preload while reset is held.
    #2;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_memwr", {31'h0, ram_MemWrite}, 32'h0);
    check("rst_addr", ram_addr, 32'h0);
    check("rst_ld", 32'(ld_cnt), 32'h0);
    fill = 1'b1;
    @(posedge clk);
    #1 fill = 1'b0;
    @(negedge clk);
    CLR_n = 1'b1;
    @(posedge clk);
    #1 check("rel_ready", {31'h0, req_ready}, 32'h1);

    // Store word / load word.
    do_req(1'b1, SZ_WORD, 1'b0, 8'h10, 32'hDEADBEEF, 0);
    do_req(1'b0, SZ_WORD, 1'b0, 8'h10, 32'h0, 0);
    check("w_rdata_abs", resp_rdata, 32'hDEADBEEF);
    check("w_cnt_abs", {28'h0, st_cnt}, 32'h1);

    // Byte store, signed and unsigned load.
    do_req(1'b1, SZ_BYTE, 1'b0, 8'h21, 32'h00000080, 0);
    do_req(1'b0, SZ_BYTE, 1'b0, 8'h21, 32'h0, 0);
    check("sb_abs", resp_rdata, 32'hFFFFFF80);
    do_req(1'b0, SZ_BYTE, 1'b1, 8'h21, 32'h0, 1);
    check("ub_abs", resp_rdata, 32'h00000080);

    // Misaligned half and illegal size.
    do_req(1'b0, SZ_HALF, 1'b0, 8'h23, 32'h0, 0);
    check("mis_cnt_abs", {28'h0, err_cnt}, 32'h1);
    do_req(1'b1, SZ_ILL, 1'b0, 8'h20, 32'h12345678, 2);

    // Long backpressure on a load.
    do_req(1'b0, SZ_HALF, 1'b1, 8'h10, 32'h0, 5);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_HALF) a[0] = 1'b0;
        if (sz == SZ_WORD) a[1:0] = 2'b00;
      end
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3));
    end

    // Reset during ISSUE of a store: write must be dropped, counters cleared.
    saved = ref_load(SZ_WORD, 1'b0, 'h30);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = ~saved;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 check("issue_wr", {31'h0, ram_MemWrite}, 32'h1);
    CLR_n = 1'b0;
    #1;
    check("arst_memwr", {31'h0, ram_MemWrite}, 32'h0);
    check("arst_valid", {31'h0, resp_valid}, 32'h0);
    check("arst_ready", {31'h0, req_ready}, 32'h1);
    check("arst_st", 32'(st_cnt), 32'h0);
    check("arst_ld", 32'(ld_cnt), 32'h0);
    check("arst_err", 32'(err_cnt), 32'h0);
    m_ld = 0; m_st = 0; m_err = 0;
    @(posedge clk);
    @(negedge clk);
    CLR_n = 1'b1;
    do_req(1'b0, SZ_WORD, 1'b0, 8'h30, 32'h0, 0);
    check("arst_keep_abs", resp_rdata, saved);

    // Load counter saturation.
    for (int n = 0; n < (1 << CNT_W) + 2; n++) do_req(1'b0, SZ_WORD, 1'b0, 8'h40, 32'h0, 0);
    check("ld_sat", {28'h0, ld_cnt}, 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
